// File: rtl/div_result_bcd.sv
// div_result_bcd
//   Sequential binary-to-BCD converter placed after the divider. Captures one
//   quotient/remainder pair per input handshake, converts both operands in
//   parallel with shift-and-add-3 (double dabble), one bit per clock, and
//   offers the packed BCD result on an output handshake.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
//   both high. in_ready is high only in IDLE; out_valid is high only in DONE
//   and stays high, with stable data, until out_ready is seen. Neither ready
//   nor valid depends combinationally on the other side's signals.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   q/r valid this cycle
//   in_ready   block can accept a pair (IDLE)
//   q, r       quotient / remainder, WIDTH bits
//   q_bcd      packed BCD quotient, digit 0 in bits [3:0]
//   r_bcd      packed BCD remainder, same packing
//   out_valid  q_bcd/r_bcd hold a finished result (DONE)
//   out_ready  consumer accepts the result
//   busy       conversion in progress (SHIFT)
//   dbg_state  current FSM state encoding (0 IDLE, 1 SHIFT, 2 DONE)

module div_result_bcd #(
   parameter int WIDTH  = 4,
   parameter int DIGITS = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [WIDTH-1:0]      q,
   input  logic [WIDTH-1:0]      r,
   output logic [4*DIGITS-1:0]   q_bcd,
   output logic [4*DIGITS-1:0]   r_bcd,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  busy,
   output logic [1:0]            dbg_state
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   state_t state, state_nxt;

   logic [WIDTH-1:0]    q_bin, r_bin;
   logic [4*DIGITS-1:0] q_acc, r_acc;
   logic [4*DIGITS-1:0] q_adj, r_adj;
   logic [4*DIGITS-1:0] q_acc_nxt, r_acc_nxt;
   logic [CW-1:0]       count;
   logic                last_shift;

   // Every digit >= 5 gets +3 before the shift, so that the doubling carries
   // correctly into the next decade. Digits are never above 9 here, so the
   // sum always fits in 4 bits.
   function automatic logic [4*DIGITS-1:0] add3(input logic [4*DIGITS-1:0] b);
      logic [4*DIGITS-1:0] res;
      res = b;
      for (int i = 0; i < DIGITS; i++) begin
         if (b[4*i +: 4] >= 4'd5)
            res[4*i +: 4] = b[4*i +: 4] + 4'd3;
      end
      return res;
   endfunction

   always_comb begin
      q_adj     = add3(q_acc);
      r_adj     = add3(r_acc);
      // Binary MSB enters BCD bit 0 as the combined register shifts left.
      q_acc_nxt = {q_adj[4*DIGITS-2:0], q_bin[WIDTH-1]};
      r_acc_nxt = {r_adj[4*DIGITS-2:0], r_bin[WIDTH-1]};
   end

   assign last_shift = (state == ST_SHIFT) && (count == CW'(WIDTH - 1));

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst)
         state <= ST_IDLE;
      else
         state <= state_nxt;
   end

   // FSM next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (in_valid)   state_nxt = ST_SHIFT;
         ST_SHIFT: if (last_shift) state_nxt = ST_DONE;
         ST_DONE:  if (out_ready)  state_nxt = ST_IDLE;
         default:                  state_nxt = ST_IDLE;
      endcase
   end

   // Datapath: operand capture, shift/adjust, result registers
   always_ff @(posedge clk) begin
      if (rst) begin
         q_bin <= '0;
         r_bin <= '0;
         q_acc <= '0;
         r_acc <= '0;
         count <= '0;
         q_bcd <= '0;
         r_bcd <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (in_valid) begin
                  q_bin <= q;
                  r_bin <= r;
                  q_acc <= '0;
                  r_acc <= '0;
                  count <= '0;
               end
            end
            ST_SHIFT: begin
               q_bin <= q_bin << 1;
               r_bin <= r_bin << 1;
               q_acc <= q_acc_nxt;
               r_acc <= r_acc_nxt;
               count <= count + 1'b1;
               // Final shift result goes straight to the outputs so that it
               // is visible on the same edge that enters DONE.
               if (last_shift) begin
                  q_bcd <= q_acc_nxt;
                  r_bcd <= r_acc_nxt;
               end
            end
            default: ;
         endcase
      end
   end

   assign in_ready  = (state == ST_IDLE);
   assign busy      = (state == ST_SHIFT);
   assign out_valid = (state == ST_DONE);
   assign dbg_state = state;

endmodule

// File: tb/tb_div_result_bcd.sv
// tb_div_result_bcd
//   Directed bench for div_result_bcd at WIDTH=4, DIGITS=2. A transaction
//   level model predicts handshake flags and result values; a compare process
//   checks every output on every falling edge after the first reset edge.
//   Directed tasks add literal expectations for values and latency.

module tb_div_result_bcd;

   localparam int WIDTH  = 4;
   localparam int DIGITS = 2;
   localparam int BW     = 4 * DIGITS;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [WIDTH-1:0] q = '0;
   logic [WIDTH-1:0] r = '0;
   logic [BW-1:0]    q_bcd, r_bcd;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic             busy;
   logic [1:0]       dbg_state;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   div_result_bcd #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .q         (q),
      .r         (r),
      .q_bcd     (q_bcd),
      .r_bcd     (r_bcd),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .busy      (busy),
      .dbg_state (dbg_state)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- helpers ----------------
   function automatic logic [BW-1:0] to_bcd(input int v);
      logic [BW-1:0] res;
      int t;
      res = '0;
      t = v;
      for (int i = 0; i < DIGITS; i++) begin
         res[4*i +: 4] = 4'(t % 10);
         t = t / 10;
      end
      return res;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- transaction model ----------------
   // A pair accepted in idle finishes WIDTH edges later; the result is then
   // offered until out_ready is seen. Reset discards everything.
   bit            m_live = 0;
   bit            m_inflight = 0;
   bit            m_done = 0;
   int            m_left = 0;
   logic [BW-1:0] m_pend_q, m_pend_r;
   logic [BW-1:0] m_q = '0, m_r = '0;
   logic [BW-1:0] exp_q[$];
   logic [BW-1:0] exp_r[$];

   always @(posedge clk) begin
      if (rst) begin
         m_live = 1;
         m_inflight = 0;
         m_done = 0;
         m_left = 0;
         m_q = '0;
         m_r = '0;
         exp_q.delete();
         exp_r.delete();
      end else if (m_inflight) begin
         m_left = m_left - 1;
         if (m_left == 0) begin
            m_inflight = 0;
            m_done = 1;
            m_q = exp_q.pop_front();
            m_r = exp_r.pop_front();
         end
      end else if (m_done) begin
         if (out_ready) m_done = 0;
      end else if (in_valid) begin
         m_inflight = 1;
         m_left = WIDTH;
         exp_q.push_back(to_bcd(int'(q)));
         exp_r.push_back(to_bcd(int'(r)));
      end
   end

   // ---------------- compare process ----------------
   always @(negedge clk) begin
      if (m_live) begin
         tests++;
         if (in_ready !== (!m_inflight && !m_done) || busy !== m_inflight ||
             out_valid !== m_done || q_bcd !== m_q || r_bcd !== m_r) begin
            fails++;
            $display("FAIL model_cmp: got rdy=%b busy=%b ov=%b q=%h r=%h expected rdy=%b busy=%b ov=%b q=%h r=%h (cycle %0d)",
                     in_ready, busy, out_valid, q_bcd, r_bcd,
                     !m_inflight && !m_done, m_inflight, m_done, m_q, m_r, cyc);
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic wait_ready();
      int n = 0;
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("in_ready_timeout", 32'(in_ready), 32'd1);
   endtask

   // Sends one pair, measures latency, checks result against literal values,
   // then optionally completes the output handshake.
   task automatic run_pair(input logic [WIDTH-1:0] qv, input logic [WIDTH-1:0] rv,
                           input logic [BW-1:0] eq, input logic [BW-1:0] er,
                           input bit do_ack);
      int lat;
      wait_ready();
      in_valid = 1'b1;
      q = qv;
      r = rv;
      @(negedge clk);
      in_valid = 1'b0;
      check("accept_drops_ready", 32'(in_ready), 32'd0);
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      check("latency", 32'(lat), 32'(WIDTH));
      check("q_bcd", 32'(q_bcd), 32'(eq));
      check("r_bcd", 32'(r_bcd), 32'(er));
      for (int i = 0; i < DIGITS; i++) begin
         if (q_bcd[4*i +: 4] > 4'd9 || r_bcd[4*i +: 4] > 4'd9) begin
            tests++;
            fails++;
            $display("FAIL digit_range: got q=%h r=%h expected digits <= 9", q_bcd, r_bcd);
         end
      end
      if (do_ack) begin
         out_ready = 1'b1;
         @(negedge clk);
         out_ready = 1'b0;
         check("ack_ov_low", 32'(out_valid), 32'd0);
         check("ack_ready_high", 32'(in_ready), 32'd1);
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int rise_cyc[2];
      logic [BW-1:0] got_q[2];
      logic [BW-1:0] got_r[2];
      int nr;
      logic prev_ov;

      // pin the model's conversion
      check("model_15", 32'(to_bcd(15)), 32'h15);
      check("model_0",  32'(to_bcd(0)),  32'h00);
      check("model_9",  32'(to_bcd(9)),  32'h09);

      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_q_bcd", 32'(q_bcd), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // basic conversions
      run_pair(4'd3,  4'd1, 8'h03, 8'h01, 1);
      run_pair(4'd15, 4'd9, 8'h15, 8'h09, 1);
      run_pair(4'd10, 4'd0, 8'h10, 8'h00, 1);
      run_pair(4'd0,  4'd0, 8'h00, 8'h00, 1);

      // backpressure: result must stay while inputs churn
      run_pair(4'd13, 4'd11, 8'h13, 8'h11, 0);
      for (int i = 0; i < 6; i++) begin
         in_valid = ~in_valid;
         q = 4'($urandom_range(0, 15));
         r = 4'($urandom_range(0, 15));
         @(negedge clk);
         check("bp_ov", 32'(out_valid), 32'd1);
         check("bp_rdy", 32'(in_ready), 32'd0);
         check("bp_q", 32'(q_bcd), 32'h13);
         check("bp_r", 32'(r_bcd), 32'h11);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check("bp_release_ov", 32'(out_valid), 32'd0);
      check("bp_release_rdy", 32'(in_ready), 32'd1);
      check("bp_keep_q", 32'(q_bcd), 32'h13);

      // back-to-back with both handshakes held high
      @(negedge clk);
      out_ready = 1'b1;
      in_valid = 1'b1;
      q = 4'd12;
      r = 4'd5;
      nr = 0;
      prev_ov = 1'b0;
      for (int i = 0; i < 16 && nr < 2; i++) begin
         @(negedge clk);
         if (!in_ready && !busy && !out_valid) begin
            // unreachable under a correct design; model flags it as well
         end
         if (busy) begin
            q = 4'd7;
            r = 4'd3;
         end
         if (out_valid && !prev_ov) begin
            rise_cyc[nr] = cyc;
            got_q[nr] = q_bcd;
            got_r[nr] = r_bcd;
            nr++;
         end
         prev_ov = out_valid;
      end
      in_valid = 1'b0;
      out_ready = 1'b0;
      check("b2b_count", 32'(nr), 32'd2);
      if (nr == 2) begin
         check("b2b_q0", 32'(got_q[0]), 32'h12);
         check("b2b_r0", 32'(got_r[0]), 32'h05);
         check("b2b_q1", 32'(got_q[1]), 32'h07);
         check("b2b_r1", 32'(got_r[1]), 32'h03);
         check("b2b_spacing", 32'(rise_cyc[1] - rise_cyc[0]), 32'(WIDTH + 2));
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      @(negedge clk);

      // reset during the second shift cycle
      wait_ready();
      in_valid = 1'b1;
      q = 4'd14;
      r = 4'd6;
      @(negedge clk);            // accept edge passed, first shift next
      in_valid = 1'b0;
      @(negedge clk);            // first shift done
      rst = 1'b1;
      @(negedge clk);            // reset edge replaces the second shift
      rst = 1'b0;
      check("mid_rst_rdy", 32'(in_ready), 32'd1);
      check("mid_rst_ov", 32'(out_valid), 32'd0);
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_q", 32'(q_bcd), 32'd0);
      check("mid_rst_r", 32'(r_bcd), 32'd0);
      run_pair(4'd9, 4'd4, 8'h09, 8'h04, 1);

      // exhaustive sweep against a tens/units split
      for (int a = 0; a < 16; a++) begin
         for (int b = 0; b < 16; b++) begin
            run_pair(4'(a), 4'(b),
                     {4'(a / 10), 4'(a % 10)},
                     {4'(b / 10), 4'(b % 10)}, 1);
         end
      end

      @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   // global watchdog
   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/div_result_bcd.md
Name: div_result_bcd

Overview:
- Sequential binary-to-BCD converter that sits directly downstream of the Division block.
- Captures one quotient/remainder pair (q, r) per handshake.
- Converts both operands in parallel using the shift-and-add-3 (double-dabble) algorithm, one bit per clock.
- Presents packed BCD digits to the display/readout logic with a valid/ready handshake.

Parameters:
- WIDTH, 4, bit width of q and r (matches the divider operand width).
- DIGITS, 2, BCD digits per operand; must satisfy 10^DIGITS > 2^WIDTH-1.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  q/r are valid this cycle.
- in_ready  output  1  block can accept a pair (high only in IDLE).
- q  input  WIDTH  quotient from the divider.
- r  input  WIDTH  remainder from the divider.
- q_bcd  output  4*DIGITS  packed BCD quotient; digit 0 in bits [3:0].
- r_bcd  output  4*DIGITS  packed BCD remainder; same packing as q_bcd.
- out_valid  output  1  q_bcd/r_bcd hold a finished result.
- out_ready  input  1  consumer accepts the result.
- busy  output  1  high in SHIFT state.

Behaviour:
- Reset: rst high at a rising edge forces the following, regardless of state (including mid-SHIFT or DONE):
  - state=IDLE, in_ready=1, out_valid=0, busy=0;
  - q_bcd=0, r_bcd=0;
  - internal shift registers and bit counter cleared.
- Any conversion in progress at reset is discarded.
- States: IDLE, SHIFT, DONE. All outputs are registered or decoded from the state register only; no combinational path from inputs to outputs.
- IDLE:
  - in_ready=1.
  - On in_valid=1: latch q and r into binary shift registers, clear both BCD accumulators, set count=0, go to SHIFT.
  - in_valid=0: stay in IDLE.
- SHIFT (busy=1, in_ready=0), each edge, independently for q and r:
  - every BCD digit >= 5 gets +3 (digits evaluated in parallel);
  - then {bcd, bin} shifts left one bit, with the bin MSB entering bcd bit 0;
  - count increments.
  - On the edge where count == WIDTH-1 (the WIDTH-th shift): write the final adjusted+shifted BCD value directly into q_bcd/r_bcd, set out_valid=1, go to DONE.
  - in_valid is ignored throughout SHIFT.
- Latency: out_valid is high exactly WIDTH rising edges after the accepting edge (4 cycles at default).
- DONE:
  - out_valid=1; q_bcd/r_bcd held stable; in_ready=0; in_valid ignored.
  - On out_ready=1: out_valid=0 and state goes to IDLE on that edge.
  - out_ready low holds DONE indefinitely.
- Throughput: minimum WIDTH+2 cycles per pair (accept, WIDTH shifts, handshake edge, back in IDLE).
- q_bcd/r_bcd change only on the final SHIFT edge and on reset. They keep the last result after the DONE→IDLE transition, until the next conversion completes.
- out_ready while not in DONE: no effect.
- Arithmetic: the add-3 result never exceeds 4 bits (input digit <= 9 before the add). No digit is ever > 9 in the outputs when the DIGITS constraint holds.
- Zero and all-ones operands need no special handling: q=0 → q_bcd=0; q=2^WIDTH-1 converts normally.

Test Plan:
- Reset, then q=3, r=1 (7/2), in_valid one cycle → in_ready falls next cycle; busy high 4 cycles; then out_valid=1 with q_bcd=8'h03, r_bcd=8'h01, exactly 4 edges after accept.
- q=15, r=9; q=10, r=0; q=0, r=0 → q_bcd/r_bcd = 8'h15/8'h09, 8'h10/8'h00, 8'h00/8'h00 respectively.
- Backpressure: hold out_ready=0 for 6 cycles after out_valid while toggling in_valid with new q/r → out_valid, q_bcd, r_bcd unchanged; in_ready stays 0. Raise out_ready → out_valid=0 next edge; in_ready=1.
- Back-to-back: in_valid and out_ready held high with q=12,r=5 then q=7,r=3 → results 8'h12/8'h05 then 8'h07/8'h03, out_valid rising edges 6 cycles apart.
- Reset mid-operation: assert rst for one edge during the 2nd SHIFT cycle → next cycle state IDLE, in_ready=1, out_valid=0, q_bcd=r_bcd=0. A subsequent q=9,r=4 converts to 8'h09/8'h04 normally.
- Exhaustive sweep: all 256 (q,r) pairs at WIDTH=4 compared against a reference decimal split (tens, units) → zero mismatches; no output digit > 9.
